// File: rtl/complex_matrix_multiplier.sv
// Streaming 4-channel complex covariance accumulator.
// It sums R[i][j] = x[i]*conj(x[j]) over each frame and emits all 16 entries as one output beat.
package complex_matrix_multiplier_pkg;

  typedef struct packed {
    logic [15:0] im;
    logic [15:0] re;
  } sample_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

module complex_matrix_multiplier
  import complex_matrix_multiplier_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned ACC_W     = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic [31:0] channel_0_base,
  input  logic [31:0] channel_1_base,
  input  logic [31:0] channel_2_base,
  input  logic [31:0] channel_3_base,
  output logic        m_axis_dout_tvalid,
  output logic        m_axis_dout_tlast,
  output logic [1:0]  m_axis_dout_tuser,
  input  logic        m_axis_dout_tready,
  output logic [63:0] result_matrix_0_0,
  output logic [63:0] result_matrix_0_1,
  output logic [63:0] result_matrix_0_2,
  output logic [63:0] result_matrix_0_3,
  output logic [63:0] result_matrix_1_0,
  output logic [63:0] result_matrix_1_1,
  output logic [63:0] result_matrix_1_2,
  output logic [63:0] result_matrix_1_3,
  output logic [63:0] result_matrix_2_0,
  output logic [63:0] result_matrix_2_1,
  output logic [63:0] result_matrix_2_2,
  output logic [63:0] result_matrix_2_3,
  output logic [63:0] result_matrix_3_0,
  output logic [63:0] result_matrix_3_1,
  output logic [63:0] result_matrix_3_2,
  output logic [63:0] result_matrix_3_3
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned NTRI  = NCH * (NCH + 1) / 2;
  localparam int unsigned NRES  = NCH * NCH;
  localparam int unsigned RES_W = 32;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  // Row-major packing of the upper triangle (i <= j) into 0..NTRI-1
  function automatic logic [3:0] tri_idx(input int i, input int j);
    return 4'(i * NCH - (i * (i - 1)) / 2 + (j - i));
  endfunction

  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return a * b;
  endfunction

  // Returns {clipped, value} after the output shift and 32-bit saturation
  function automatic logic [RES_W:0] sat_fmt(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> OUT_SHIFT;
    if (s > SAT_MAX) begin
      return {1'b1, 32'h7FFF_FFFF};
    end else if (s < SAT_MIN) begin
      return {1'b1, 32'h8000_0000};
    end
    return {1'b0, s[RES_W-1:0]};
  endfunction

  sample_t x [NCH];

  state_e state_q, state_d;
  logic   s_ready_q, s_ready_d;
  logic   m_valid_q, m_valid_d;
  logic [1:0] m_user_q, m_user_d;
  logic   started_q, started_d;
  logic   first_user_q, first_user_d;
  logic   prod_vld_q;
  logic   accept_c, load_res_c, clear_c, sat_any_c;

  logic signed [ACC_W-1:0] prod_re_d [NTRI];
  logic signed [ACC_W-1:0] prod_im_d [NTRI];
  logic signed [ACC_W-1:0] prod_re_q [NTRI];
  logic signed [ACC_W-1:0] prod_im_q [NTRI];
  logic signed [ACC_W-1:0] acc_re_d  [NTRI];
  logic signed [ACC_W-1:0] acc_im_d  [NTRI];
  logic signed [ACC_W-1:0] acc_re_q  [NTRI];
  logic signed [ACC_W-1:0] acc_im_q  [NTRI];

  logic [2*RES_W-1:0] res_d [NRES];
  logic [2*RES_W-1:0] res_q [NRES];
  logic [RES_W:0]     fmt_re, fmt_im;

  assign x[0] = sample_t'(channel_0_base);
  assign x[1] = sample_t'(channel_1_base);
  assign x[2] = sample_t'(channel_2_base);
  assign x[3] = sample_t'(channel_3_base);

  assign accept_c = clken & s_axis_tvalid & s_ready_q;

  // Control FSM: next state, handshake flags and frame sideband
  always_comb begin
    state_d      = state_q;
    s_ready_d    = 1'b0;
    m_valid_d    = m_valid_q;
    m_user_d     = m_user_q;
    started_d    = started_q;
    first_user_d = first_user_q;
    load_res_c   = 1'b0;
    clear_c      = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (accept_c && s_axis_tlast) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!m_valid_q) begin
          load_res_c = 1'b1;
          m_valid_d  = 1'b1;
          m_user_d   = {first_user_q, sat_any_c};
        end else if (m_axis_dout_tready) begin
          state_d   = ST_ACCUM;
          m_valid_d = 1'b0;
          m_user_d  = '0;
          clear_c   = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    if (accept_c && !started_q) begin
      started_d    = 1'b1;
      first_user_d = s_axis_tuser;
    end
    if (clear_c) begin
      started_d    = 1'b0;
      first_user_d = 1'b0;
    end
    s_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_ACCUM;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_user_q     <= '0;
      started_q    <= 1'b0;
      first_user_q <= 1'b0;
      prod_vld_q   <= 1'b0;
    end else if (clken) begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_user_q     <= m_user_d;
      started_q    <= started_d;
      first_user_q <= first_user_d;
      prod_vld_q   <= accept_c;
    end
  end

  // Upper-triangle products x[i]*conj(x[j]); diagonal imaginary is identically zero
  always_comb begin
    for (int k = 0; k < NTRI; k++) begin
      prod_re_d[k] = '0;
      prod_im_d[k] = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      for (int j = i; j < NCH; j++) begin
        prod_re_d[tri_idx(i, j)] = ACC_W'(mul16(x[i].re, x[j].re))
                                 + ACC_W'(mul16(x[i].im, x[j].im));
        if (i != j) begin
          prod_im_d[tri_idx(i, j)] = ACC_W'(mul16(x[i].im, x[j].re))
                                   - ACC_W'(mul16(x[i].re, x[j].im));
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NTRI; k++) begin
      acc_re_d[k] = acc_re_q[k];
      acc_im_d[k] = acc_im_q[k];
      if (clear_c) begin
        acc_re_d[k] = '0;
        acc_im_d[k] = '0;
      end else if (prod_vld_q) begin
        acc_re_d[k] = acc_re_q[k] + prod_re_q[k];
        acc_im_d[k] = acc_im_q[k] + prod_im_q[k];
      end
    end
  end

  // Full 4x4 result view; lower triangle mirrors the upper as its conjugate
  always_comb begin
    sat_any_c = 1'b0;
    fmt_re    = '0;
    fmt_im    = '0;
    for (int r = 0; r < NRES; r++) res_d[r] = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        if (i <= j) begin
          fmt_re = sat_fmt(acc_re_q[tri_idx(i, j)]);
          fmt_im = (i == j) ? '0 : sat_fmt(acc_im_q[tri_idx(i, j)]);
        end else begin
          fmt_re = sat_fmt(acc_re_q[tri_idx(j, i)]);
          fmt_im = sat_fmt(-acc_im_q[tri_idx(j, i)]);
        end
        res_d[i*NCH+j] = {fmt_im[RES_W-1:0], fmt_re[RES_W-1:0]};
        sat_any_c      = sat_any_c | fmt_re[RES_W] | fmt_im[RES_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NTRI; k++) begin
        prod_re_q[k] <= '0;
        prod_im_q[k] <= '0;
        acc_re_q[k]  <= '0;
        acc_im_q[k]  <= '0;
      end
      for (int r = 0; r < NRES; r++) res_q[r] <= '0;
    end else if (clken) begin
      for (int k = 0; k < NTRI; k++) begin
        prod_re_q[k] <= prod_re_d[k];
        prod_im_q[k] <= prod_im_d[k];
        acc_re_q[k]  <= acc_re_d[k];
        acc_im_q[k]  <= acc_im_d[k];
      end
      if (load_res_c) begin
        for (int r = 0; r < NRES; r++) res_q[r] <= res_d[r];
      end
    end
  end

  assign s_axis_tready      = s_ready_q;
  assign m_axis_dout_tvalid = m_valid_q;
  assign m_axis_dout_tlast  = m_valid_q;
  assign m_axis_dout_tuser  = m_user_q;

  assign result_matrix_0_0 = res_q[0];
  assign result_matrix_0_1 = res_q[1];
  assign result_matrix_0_2 = res_q[2];
  assign result_matrix_0_3 = res_q[3];
  assign result_matrix_1_0 = res_q[4];
  assign result_matrix_1_1 = res_q[5];
  assign result_matrix_1_2 = res_q[6];
  assign result_matrix_1_3 = res_q[7];
  assign result_matrix_2_0 = res_q[8];
  assign result_matrix_2_1 = res_q[9];
  assign result_matrix_2_2 = res_q[10];
  assign result_matrix_2_3 = res_q[11];
  assign result_matrix_3_0 = res_q[12];
  assign result_matrix_3_1 = res_q[13];
  assign result_matrix_3_2 = res_q[14];
  assign result_matrix_3_3 = res_q[15];

endmodule

// File: tb/tb_complex_matrix_multiplier.sv
// Randomized self-checking bench for complex_matrix_multiplier against a plain-arithmetic
// covariance model of each frame.
module tb_complex_matrix_multiplier;

  localparam int unsigned OUT_SHIFT = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [31:0] channel_0_base, channel_1_base, channel_2_base, channel_3_base;
  logic        m_axis_dout_tvalid;
  logic        m_axis_dout_tlast;
  logic [1:0]  m_axis_dout_tuser;
  logic        m_axis_dout_tready;
  logic [63:0] res [16];

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] beats [$];
  logic [63:0]  exp_res [16];
  logic         exp_sat;

  always #5 clk = ~clk;

  complex_matrix_multiplier #(.OUT_SHIFT(OUT_SHIFT), .ACC_W(48)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .clken              (clken),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tready      (s_axis_tready),
    .channel_0_base     (channel_0_base),
    .channel_1_base     (channel_1_base),
    .channel_2_base     (channel_2_base),
    .channel_3_base     (channel_3_base),
    .m_axis_dout_tvalid (m_axis_dout_tvalid),
    .m_axis_dout_tlast  (m_axis_dout_tlast),
    .m_axis_dout_tuser  (m_axis_dout_tuser),
    .m_axis_dout_tready (m_axis_dout_tready),
    .result_matrix_0_0  (res[0]),
    .result_matrix_0_1  (res[1]),
    .result_matrix_0_2  (res[2]),
    .result_matrix_0_3  (res[3]),
    .result_matrix_1_0  (res[4]),
    .result_matrix_1_1  (res[5]),
    .result_matrix_1_2  (res[6]),
    .result_matrix_1_3  (res[7]),
    .result_matrix_2_0  (res[8]),
    .result_matrix_2_1  (res[9]),
    .result_matrix_2_2  (res[10]),
    .result_matrix_2_3  (res[11]),
    .result_matrix_3_0  (res[12]),
    .result_matrix_3_1  (res[13]),
    .result_matrix_3_2  (res[14]),
    .result_matrix_3_3  (res[15])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint comp(input logic [127:0] v, input int ch, input bit imag);
    logic [15:0] raw;
    raw = v[ch*32 + (imag ? 16 : 0) +: 16];
    return longint'(signed'(raw));
  endfunction

  function automatic logic [31:0] sat32(input longint v);
    longint s;
    s = v >>> OUT_SHIFT;
    if (s > 64'sd2147483647) begin
      exp_sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (s < -64'sd2147483648) begin
      exp_sat = 1'b1;
      return 32'h8000_0000;
    end
    return s[31:0];
  endfunction

  // Direct evaluation of sum over the frame of x[i]*conj(x[j]) for all 16 entries
  function automatic void compute_expected();
    longint sr, si, ai, bi, aj, bj;
    logic [31:0] fr, fi;
    exp_sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sr = 0;
        si = 0;
        foreach (beats[b]) begin
          ai = comp(beats[b], i, 1'b0);
          bi = comp(beats[b], i, 1'b1);
          aj = comp(beats[b], j, 1'b0);
          bj = comp(beats[b], j, 1'b1);
          sr += ai * aj + bi * bj;
          si += bi * aj - ai * bj;
        end
        fr = sat32(sr);
        fi = sat32(si);
        exp_res[i*4+j] = {fi, fr};
      end
    end
  endfunction

  task automatic do_reset(input string name);
    reset_n            = 1'b0;
    clken              = 1'b1;
    s_axis_tvalid      = 1'b0;
    s_axis_tlast       = 1'b0;
    s_axis_tuser       = 1'b0;
    m_axis_dout_tready = 1'b0;
    repeat (16) step();
    check({name, "_s_ready"}, 64'(s_axis_tready), 64'd0);
    check({name, "_m_valid"}, 64'(m_axis_dout_tvalid), 64'd0);
    check({name, "_m_user"}, 64'(m_axis_dout_tuser), 64'd0);
    check({name, "_R00"}, res[0], 64'd0);
    check({name, "_R33"}, res[15], 64'd0);
    reset_n = 1'b1;
    step();
    check({name, "_ready_rel"}, 64'(s_axis_tready), 64'd1);
  endtask

  task automatic run_frame(input string name, input int gap_pct, input int bp,
                           input int fstall, input bit tuser0);
    bit acc;
    bit stable;
    int guard;
    int lat;
    logic [1:0] exp_user;
    compute_expected();
    exp_user = {tuser0, exp_sat};
    m_axis_dout_tready = 1'b0;
    clken = 1'b1;
    for (int b = 0; b < beats.size(); b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        step();
      end
      {channel_3_base, channel_2_base, channel_1_base, channel_0_base} = beats[b];
      s_axis_tlast  = (b == beats.size() - 1);
      s_axis_tuser  = (b == 0) ? tuser0 : 1'($urandom);
      s_axis_tvalid = 1'b1;
      guard = 0;
      acc   = 1'b0;
      do begin
        acc = s_axis_tready & clken;
        step();
        guard++;
      end while (!acc && guard < 64);
      if (!acc) begin
        check({name, "_accept_timeout"}, 64'(acc), 64'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check({name, "_flush_ready"}, 64'(s_axis_tready), 64'd0);
    lat = 0;
    while (!m_axis_dout_tvalid && lat < 40) begin
      clken = (lat >= fstall);
      step();
      lat++;
    end
    clken = 1'b1;
    check({name, "_latency"}, 64'(lat), 64'(2 + fstall));
    for (int r = 0; r < 16; r++)
      check($sformatf("%s_R%0d%0d", name, r / 4, r % 4), res[r], exp_res[r]);
    check({name, "_tlast"}, 64'(m_axis_dout_tlast), 64'd1);
    check({name, "_tuser"}, 64'(m_axis_dout_tuser), 64'(exp_user));
    check({name, "_hold_ready"}, 64'(s_axis_tready), 64'd0);
    stable = 1'b1;
    for (int c = 0; c < bp; c++) begin
      step();
      for (int r = 0; r < 16; r++) if (res[r] !== exp_res[r]) stable = 1'b0;
      if (!m_axis_dout_tvalid || s_axis_tready || m_axis_dout_tuser !== exp_user) stable = 1'b0;
    end
    if (bp > 0) check({name, "_bp_stable"}, 64'(stable), 64'd1);
    m_axis_dout_tready = 1'b1;
    step();
    check({name, "_valid_drop"}, 64'(m_axis_dout_tvalid), 64'd0);
    check({name, "_user_clr"}, 64'(m_axis_dout_tuser), 64'd0);
    check({name, "_ready_back"}, 64'(s_axis_tready), 64'd1);
    m_axis_dout_tready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    channel_0_base = '0;
    channel_1_base = '0;
    channel_2_base = '0;
    channel_3_base = '0;
    do_reset("reset");

    beats.delete();
    beats.push_back({4{32'h0000_0001}});
    run_frame("ones", 0, 0, 0, 1'b0);

    beats.delete();
    beats.push_back({32'h0, 32'h0, 32'h0, 32'h0004_0003});
    run_frame("three_four", 0, 0, 0, 1'b1);

    beats.delete();
    beats.push_back({32'h0, 32'h0, 32'h0000_0002, 32'h0001_0001});
    run_frame("pair_bp", 0, 20, 0, 1'b0);

    beats.delete();
    repeat (256) beats.push_back({4{32'h7FFF_7FFF}});
    run_frame("full_scale", 0, 0, 0, 1'b1);

    beats.delete();
    beats.push_back({4{32'h0000_0001}});
    run_frame("after_clear", 0, 0, 3, 1'b0);

    for (int f = 0; f < 6; f++) begin
      beats.delete();
      repeat ($urandom_range(1, 20))
        beats.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      run_frame($sformatf("rand%0d", f), 30, $urandom_range(0, 4),
                $urandom_range(0, 3), 1'($urandom));
    end

    // Abort a frame with reset, then show the next frame starts from empty accumulators
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    repeat (3) begin
      {channel_3_base, channel_2_base, channel_1_base, channel_0_base} =
        {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    do_reset("midreset");
    beats.delete();
    beats.push_back({32'h0, 32'hFFFF_0000, 32'h0003_FFFE, 32'h8000_8000});
    run_frame("post_reset", 0, 2, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
